// File: rtl/perceptron_pkg.sv
// Shared widths, weight limits and FSM state encoding for the perceptron trainer.
package perceptron_pkg;

  localparam int DATA_W     = 18;
  localparam int ACC_W      = 48;
  localparam int DSP_SLICES = 16;

  // Representable range of one signed 18-bit weight.
  localparam logic signed [DATA_W-1:0] W_MAX = 18'sh1FFFF;
  localparam logic signed [DATA_W-1:0] W_MIN = 18'sh20000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DECIDE,
    UPDATE,
    DONE
  } state_t;

endpackage

// File: rtl/sat_addsub18.sv
// 18-bit signed add/subtract for one weight lane.
// With PERCEPTRON_SATURATE_EN defined the result clamps to the 18-bit range,
// otherwise it wraps two's complement.
module sat_addsub18
  import perceptron_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     sub,
  output logic signed [DATA_W-1:0] y
);

  logic signed [DATA_W:0] full;

  // One extra bit of headroom exposes overflow in the sign bits.
  always_comb begin
    full = sub ? ($signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b}))
               : ($signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b}));
`ifdef PERCEPTRON_SATURATE_EN
    if (full[DATA_W] != full[DATA_W-1]) begin
      y = full[DATA_W] ? W_MIN : W_MAX;
    end else begin
      y = full[DATA_W-1:0];
    end
`else
    y = full[DATA_W-1:0];
`endif
  end

`ifndef PERCEPTRON_SATURATE_EN
  logic carry_unused;
  assign carry_unused = full[DATA_W];
`endif

endmodule

// File: rtl/perceptron_weight_update.sv
// Perceptron training controller: captures a sample, waits for the external
// weighted-sum pipeline, judges the prediction and, on a training error,
// updates the weights one lane per cycle through a single shared adder.
// Optional macro: PERCEPTRON_SATURATE_EN (clamp weight updates instead of wrap).
module perceptron_weight_update
  import perceptron_pkg::*;
#(
  parameter int N           = 8,
  parameter int SUM_LATENCY = 10,
  parameter int LR_SHIFT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic [DATA_W*N-1:0]   x_in,
  input  logic                  label,
  input  logic                  train_en,
  output logic [DATA_W*N-1:0]   x_out,
  output logic [DATA_W*N-1:0]   w,
  input  logic [ACC_W-1:0]      sum,
  output logic                  done,
  output logic                  error_flag
);

  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(SUM_LATENCY + 1);

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [LANE_W-1:0]          lane_q;
  logic                       label_q;
  logic                       train_q;
  logic                       pred_pos;
  logic                       mispredict;
  int                         lane_base;
  logic signed [DATA_W-1:0]   x_lane;
  logic signed [DATA_W-1:0]   w_lane;
  logic signed [DATA_W-1:0]   delta;
  logic signed [DATA_W-1:0]   w_next;
  logic                       sum_unused;

  // Only the sign of the accumulated sum matters for the prediction.
  assign sum_unused = ^sum[ACC_W-2:0];
  assign pred_pos   = !sum[ACC_W-1];
  assign mispredict = (pred_pos != label_q);

  // Select the active lane and form its learning-rate-scaled step.
  always_comb begin
    lane_base = int'(lane_q) * DATA_W;
    x_lane    = x_out[lane_base +: DATA_W];
    w_lane    = w[lane_base +: DATA_W];
    delta     = x_lane >>> LR_SHIFT;
  end

  sat_addsub18 u_addsub (
    .a   (w_lane),
    .b   (delta),
    .sub (!label_q),
    .y   (w_next)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    sample_ready = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) state_d = WAIT;
      end
      WAIT:   if (cnt_q <= CNT_W'(1)) state_d = DECIDE;
      DECIDE: state_d = (mispredict && train_q) ? UPDATE : DONE;
      UPDATE: if (lane_q == LANE_W'(N - 1)) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample capture, latency counter, decision flag and weight write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_out      <= '0;
      w          <= '0;
      cnt_q      <= '0;
      lane_q     <= '0;
      label_q    <= 1'b0;
      train_q    <= 1'b0;
      error_flag <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            x_out      <= x_in;
            label_q    <= label;
            train_q    <= train_en;
            error_flag <= 1'b0;
            cnt_q      <= CNT_W'(SUM_LATENCY);
            lane_q     <= '0;
          end
        end
        WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        DECIDE: error_flag <= mispredict;
        UPDATE: begin
          w[lane_base +: DATA_W] <= w_next;
          lane_q                 <= lane_q + LANE_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_weight_update.sv
// Directed self-checking bench for perceptron_weight_update (default parameters).
// Latency k counts falling edges after the accept edge: k=1 is the first.
module tb_perceptron_weight_update;

  localparam int N  = 8;
  localparam int DW = 18;
  localparam int XW = DW * N;

  logic          clk;
  logic          rst;
  logic          sample_valid;
  logic          sample_ready;
  logic [XW-1:0] x_in;
  logic          label;
  logic          train_en;
  logic [XW-1:0] x_out;
  logic [XW-1:0] w;
  logic [47:0]   sum;
  logic          done;
  logic          error_flag;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [47:0] SUM_ZERO = 48'h0;
  localparam logic [47:0] SUM_NEG  = 48'hFFFF_FFFF_FFFF;

  perceptron_weight_update #(.N(8), .SUM_LATENCY(10), .LR_SHIFT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .x_in         (x_in),
    .label        (label),
    .train_en     (train_en),
    .x_out        (x_out),
    .w            (w),
    .sum          (sum),
    .done         (done),
    .error_flag   (error_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one sample once the block is idle; return latency (-1 on timeout).
  task automatic run_sample(input logic [XW-1:0] xv, input logic [47:0] sv,
                            input logic lbl, input logic tr,
                            output int lat, output logic err);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!sample_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    x_in = xv; sum = sv; label = lbl; train_en = tr; sample_valid = 1'b1;
    @(posedge clk);
    lat = -1;
    err = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) sample_valid = 1'b0;
      if (done) begin
        lat = k;
        err = error_flag;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (w !== '0) begin n_fail++; $display("FAIL reset_w got=%h exp=0", w); end
    n_checks++; if (x_out !== '0) begin n_fail++; $display("FAIL reset_x_out got=%h exp=0", x_out); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", error_flag); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", sample_ready); end
  endtask

  task automatic test_no_error();
    logic [XW-1:0] xv;
    int lat;
    logic err;
    for (int i = 0; i < N; i++) xv[i*DW +: DW] = 18'(100 * (i + 1));
    run_sample(xv, SUM_ZERO, 1'b1, 1'b1, lat, err);
    n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL noerr_latency got=%0d exp=12", lat); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL noerr_flag got=%b exp=0", err); end
    n_checks++; if (w !== '0) begin n_fail++; $display("FAIL noerr_w got=%h exp=0", w); end
    n_checks++; if (x_out !== xv) begin n_fail++; $display("FAIL noerr_x_out got=%h exp=%h", x_out, xv); end
  endtask

  task automatic test_error_update();
    logic [XW-1:0] xv, exp_w;
    int lat;
    logic err;
    xv = '0;
    xv[17:0] = 18'd160;
    run_sample(xv, SUM_ZERO, 1'b0, 1'b1, lat, err);
    exp_w = '0;
    exp_w[17:0] = 18'h3FFF6;  // -10
    n_checks++; if (lat !== 20) begin n_fail++; $display("FAIL upd_latency got=%0d exp=20", lat); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL upd_flag got=%b exp=1", err); end
    n_checks++; if (w !== exp_w) begin n_fail++; $display("FAIL upd_w got=%h exp=%h", w, exp_w); end
    // Negative inputs: arithmetic shift keeps the sign (-160 -> -10, -1 -> -1).
    xv = '0;
    xv[35:18] = 18'h3FF60;  // -160
    xv[53:36] = 18'h3FFFF;  // -1
    run_sample(xv, SUM_ZERO, 1'b0, 1'b1, lat, err);
    exp_w[35:18] = 18'd10;
    exp_w[53:36] = 18'd1;
    n_checks++; if (w !== exp_w) begin n_fail++; $display("FAIL upd_neg_w got=%h exp=%h", w, exp_w); end
  endtask

  task automatic test_saturate();
    logic [XW-1:0] xv;
    logic [17:0] exp_w0;
    int lat;
    logic err;
    apply_reset();
    xv = '0;
    xv[17:0] = 18'd131071;  // step 8191
    for (int i = 0; i < 16; i++) run_sample(xv, SUM_NEG, 1'b1, 1'b1, lat, err);
    xv[17:0] = 18'd224;     // step 14
    run_sample(xv, SUM_NEG, 1'b1, 1'b1, lat, err);
    n_checks++; if (w[17:0] !== 18'd131070) begin n_fail++; $display("FAIL sat_preload got=%0d exp=131070", $signed(w[17:0])); end
    xv[17:0] = 18'd1600;    // step 100
    run_sample(xv, SUM_NEG, 1'b1, 1'b1, lat, err);
`ifdef PERCEPTRON_SATURATE_EN
    exp_w0 = 18'd131071;
`else
    exp_w0 = 18'h20062;     // -130974
`endif
    n_checks++; if (w[17:0] !== exp_w0) begin n_fail++; $display("FAIL sat_w0 got=%0d exp=%0d", $signed(w[17:0]), $signed(exp_w0)); end
    n_checks++; if (w[XW-1:18] !== '0) begin n_fail++; $display("FAIL sat_other got=%h exp=0", w[XW-1:18]); end
  endtask

  task automatic test_back_to_back();
    logic [XW-1:0] xa, xb, exp_w;
    int lat;
    logic err;
    logic busy_ready;
    int accept_b;
    int done_b;
    apply_reset();
    xa = '0;
    xa[17:0] = 18'd160;
    run_sample(xa, SUM_ZERO, 1'b0, 1'b1, lat, err);  // w0 = -10
    exp_w = '0;
    exp_w[17:0] = 18'h3FFF6;
    // Sample A: mispredicted but inference only; sample B follows with valid held.
    xa[17:0] = 18'd480;
    xb = '0;
    xb[17:0] = 18'd320;
    @(negedge clk);
    x_in = xa; sum = SUM_ZERO; label = 1'b0; train_en = 1'b0; sample_valid = 1'b1;
    @(posedge clk);
    busy_ready = 1'b0;
    accept_b = -1;
    done_b = -1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (k <= 11 && sample_ready) busy_ready = 1'b1;
      if (k == 12) begin
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_a got=%b exp=1", done); end
        n_checks++; if (error_flag !== 1'b1) begin n_fail++; $display("FAIL b2b_err_a got=%b exp=1", error_flag); end
        n_checks++; if (w !== exp_w) begin n_fail++; $display("FAIL b2b_w_a got=%h exp=%h", w, exp_w); end
        x_in = xb; label = 1'b0; train_en = 1'b1;
      end
      if (k == 13) begin
        n_checks++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got=%b exp=1", sample_ready); end
      end
      if (k > 13 && accept_b < 0 && !sample_ready) begin
        accept_b = k;
        sample_valid = 1'b0;
      end
      if (k > 13 && done) begin
        done_b = k;
        break;
      end
    end
    sample_valid = 1'b0;
    n_checks++; if (busy_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_ready got=%b exp=0", busy_ready); end
    n_checks++; if (accept_b !== 14) begin n_fail++; $display("FAIL b2b_accept_b got=%0d exp=14", accept_b); end
    n_checks++; if (done_b !== 33) begin n_fail++; $display("FAIL b2b_done_b got=%0d exp=33", done_b); end
    exp_w[17:0] = 18'h3FFE2;  // -10 - 20 = -30
    n_checks++; if (w !== exp_w) begin n_fail++; $display("FAIL b2b_w_b got=%h exp=%h", w, exp_w); end
  endtask

  task automatic test_reset_mid_update();
    logic [XW-1:0] xv, exp_w;
    logic saw_done;
    logic not_ready;
    apply_reset();
    for (int i = 0; i < N; i++) xv[i*DW +: DW] = 18'(16 * (i + 1));
    @(negedge clk);
    x_in = xv; sum = SUM_NEG; label = 1'b1; train_en = 1'b1; sample_valid = 1'b1;
    @(posedge clk);
    saw_done = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) sample_valid = 1'b0;
      if (done) saw_done = 1'b1;
    end
    // Now mid-UPDATE on lane 3: lanes 0..2 already written.
    exp_w = '0;
    exp_w[17:0]  = 18'd1;
    exp_w[35:18] = 18'd2;
    exp_w[53:36] = 18'd3;
    n_checks++; if (w !== exp_w) begin n_fail++; $display("FAIL mid_lanes got=%h exp=%h", w, exp_w); end
    rst = 1'b1;
    #1;
    n_checks++; if (w !== '0) begin n_fail++; $display("FAIL mid_rst_w got=%h exp=0", w); end
    n_checks++; if (x_out !== '0) begin n_fail++; $display("FAIL mid_rst_x got=%h exp=0", x_out); end
    n_checks++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got=%b exp=1", sample_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    not_ready = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (!sample_ready) not_ready = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done got=%b exp=0", saw_done); end
    n_checks++; if (not_ready !== 1'b0) begin n_fail++; $display("FAIL mid_stays_idle got=%b exp=0", not_ready); end
    n_checks++; if (w !== '0) begin n_fail++; $display("FAIL mid_after_w got=%h exp=0", w); end
  endtask

  initial begin
    sample_valid = 1'b0;
    x_in = '0;
    label = 1'b0;
    train_en = 1'b0;
    sum = '0;
    test_reset();
    test_no_error();
    test_error_update();
    test_saturate();
    test_back_to_back();
    test_reset_mid_update();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perceptron_weight_update.md
PERCEPTRON_WEIGHT_UPDATE -- requirements
Module: perceptron_weight_update

Interface
REQ-001 SHALL have parameter N, default 8: number of 18-bit inputs and weights.
REQ-002 SHALL have parameter SUM_LATENCY, default 10: cycles from x_out/w stable to sum valid in the downstream weighted-sum pipeline.
REQ-003 SHALL have parameter LR_SHIFT, default 4: learning rate as 2^-LR_SHIFT, applied as an arithmetic right shift.
REQ-004 SHALL have one clock; reset is asynchronous and active-high; ports: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port sample_valid  input  1  new training sample offered.
REQ-006 SHALL have port sample_ready  output  1  block idle and accepting.
REQ-007 SHALL have port x_in  input  18*N  signed inputs, lane i at bits [18i+17:18i].
REQ-008 SHALL have port label  input  1  target class: 1 = +1, 0 = -1.
REQ-009 SHALL have port train_en  input  1  sampled with the sample: 1 = update on error, 0 = inference only.
REQ-010 SHALL have port x_out  output  18*N  registered sample driven to the weighted-sum block.
REQ-011 SHALL have port w  output  18*N  current signed weights driven to the weighted-sum block.
REQ-012 SHALL have port sum  input  48  signed accumulated result returned by the weighted-sum block.
REQ-013 SHALL have port done  output  1  one-cycle pulse at sample completion.
REQ-014 SHALL have port error_flag  output  1  misprediction of the last sample, valid from done until the next accept.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DECIDE, UPDATE, DONE; sample_ready is 1 only in IDLE.
REQ-016 SHALL accept a sample on sample_valid&&sample_ready, capture x_in/label/train_en into x_out and internal registers, and enter WAIT.
REQ-017 SHALL stay in WAIT for exactly SUM_LATENCY cycles, counting on a down-counter loaded at accept, then enter DECIDE.
REQ-018 SHALL predict +1 when sum[47]==0 (sum of 0 counts as +1) and -1 otherwise.
REQ-019 SHALL in DECIDE set error_flag = (prediction != label).
REQ-020 SHALL in DECIDE go to UPDATE when error_flag is 1 and train_en is 1; otherwise go to DONE.
REQ-021 SHALL in UPDATE process one lane per cycle, i = 0..N-1: w_i <= w_i + d for label=1 and w_i - d for label=0, where d = x_i >>> LR_SHIFT (sign-preserving); after lane N-1, go to DONE.
REQ-022 SHALL in DONE assert done for one cycle, then return to IDLE.
REQ-023 SHALL pulse done SUM_LATENCY+2 cycles after the accept edge when there is no update, and SUM_LATENCY+2+N cycles after it when there is an update.
REQ-024 SHALL hold x_out and w stable from accept through DECIDE.
REQ-025 SHALL ignore sample_valid outside IDLE; a sample held valid is accepted on the first IDLE cycle.

Reset
REQ-026 SHALL on rst, at any time including mid-UPDATE, force IDLE, all weights to 0, x_out to 0, done=0, error_flag=0, and the counters to 0; sample_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, when PERCEPTRON_SATURATE_EN is defined, clamp each weight update result to [-131072, 131071].
REQ-028 SHALL, when PERCEPTRON_SATURATE_EN is undefined, wrap each weight update result modulo 2^18 (two's complement).

Structure
REQ-029 SHALL take DATA_W=18, ACC_W=48, the DSP slice count 16, and the FSM state enum from shared package perceptron_pkg.
REQ-030 SHALL place the 18-bit add/subtract with optional clamp in one sub-module, sat_addsub18, instantiated once and time-shared across lanes.

Verification
REQ-031 SHALL cover: assert rst -> w=0, x_out=0, sample_ready=1, done=0.
REQ-032 SHALL cover: weights 0, sum held 0, label=1, train_en=1 -> done at accept+12, error_flag=0, weights unchanged.
REQ-033 SHALL cover: weights 0, x_in lane0=160, sum 0, label=0, train_en=1 -> error_flag=1, w0=-10, other lanes 0, done at accept+20.
REQ-034 SHALL cover: w0=131070, x lane0=1600, sum negative, label=1 -> w0=131071 with PERCEPTRON_SATURATE_EN; w0=-130974 without.
REQ-035 SHALL cover: sample_valid held high for two samples -> sample_ready low while busy, second sample accepted the cycle after done, train_en=0 sample leaves weights unchanged despite error_flag=1.
REQ-036 SHALL cover: rst pulsed during UPDATE lane 3 -> IDLE, all weights 0, no done pulse.
